snn_timestep_sequencer: RTL and testbench

SNN_TIMESTEP_SEQUENCER -- requirements
Module: snn_timestep_sequencer

---
 rtl/snn_timestep_sequencer.sv | 162 ++++++++++++++++
 tb/tb_snn_timestep_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_timestep_sequencer.sv
// snn_timestep_sequencer: timestep controller for one layer of LIF neurons.
// Ports: clk/rst_n, start/abort, in_req/in_valid encoder handshake,
//   neuron_rst/neuron_en/inhib_out to the layer, spike_vec from it,
//   busy/done status and winner_idx/winner_count/winner_valid result.

package pa_SnnAccelerator;
    localparam int FP_WIDTH = 16;
    localparam logic signed [FP_WIDTH-1:0] INHIB_WEIGHT_DEF = -16'sd256;
endpackage

module snn_timestep_sequencer
    import pa_SnnAccelerator::*;
#(
    parameter int NUM_NEURONS  = 16,
    parameter int TIMESTEPS    = 350,
    parameter int CNT_WIDTH    = 8,
    parameter int POTENT_WIDTH = FP_WIDTH,
    parameter logic signed [POTENT_WIDTH-1:0] INHIB_WEIGHT =
        POTENT_WIDTH'(INHIB_WEIGHT_DEF),
    localparam int IDX_WIDTH =
        (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    output logic                           in_req,
    input  logic                           in_valid,
    output logic                           neuron_rst,
    output logic                           neuron_en,
    input  logic [NUM_NEURONS-1:0]         spike_vec,
    output logic signed [POTENT_WIDTH-1:0] inhib_out,
    output logic                           busy,
    output logic                           done,
    output logic [IDX_WIDTH-1:0]           winner_idx,
    output logic [CNT_WIDTH-1:0]           winner_count,
    output logic                           winner_valid
);

    localparam int STEP_W = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TIMESTEPS - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX =
        IDX_WIDTH'(NUM_NEURONS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE, CLEAR, REQ, STEP, SAMPLE, ARGMAX, DONE
    } state_t;

    state_t                 state;
    state_t                 nxt;
    logic [CNT_WIDTH-1:0]   cnt [NUM_NEURONS];
    logic [STEP_W-1:0]      step;
    logic [IDX_WIDTH-1:0]   scan;
    logic [IDX_WIDTH-1:0]   best_idx;
    logic [CNT_WIDTH-1:0]   best_cnt;
    logic [CNT_WIDTH-1:0]   scan_cnt;
    logic                   take;
    logic [IDX_WIDTH-1:0]   fin_idx;
    logic [CNT_WIDTH-1:0]   fin_cnt;

    always_comb begin
        nxt = state;
        if (abort && state != IDLE) begin
            nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start && !abort) nxt = CLEAR;
                CLEAR:   nxt = REQ;
                REQ:     if (in_valid) nxt = STEP;
                STEP:    nxt = SAMPLE;
                SAMPLE:  nxt = (step == LAST_STEP) ? ARGMAX : REQ;
                ARGMAX:  if (scan == LAST_IDX) nxt = DONE;
                DONE:    nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // Strictly-greater compare keeps the lowest index on ties.
    always_comb begin
        scan_cnt = cnt[scan];
        take     = scan_cnt > best_cnt;
        fin_cnt  = take ? scan_cnt : best_cnt;
        fin_idx  = take ? scan : best_idx;
    end

    // Outputs are registered from the next state so they line up
    // with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_req       <= 1'b0;
            neuron_en    <= 1'b0;
            neuron_rst   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            inhib_out    <= '0;
            winner_idx   <= '0;
            winner_count <= '0;
            winner_valid <= 1'b0;
            step         <= '0;
            scan         <= '0;
            best_idx     <= '0;
            best_cnt     <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
        end else begin
            state      <= nxt;
            in_req     <= (nxt == REQ);
            neuron_en  <= (nxt == STEP);
            neuron_rst <= (nxt == CLEAR);
            busy       <= (nxt != IDLE);
            done       <= (nxt == DONE);
            if (abort && state != IDLE) begin
                inhib_out <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (nxt == CLEAR) begin
                            inhib_out    <= '0;
                            winner_idx   <= '0;
                            winner_count <= '0;
                            winner_valid <= 1'b0;
                            step         <= '0;
                            scan         <= '0;
                            best_idx     <= '0;
                            best_cnt     <= '0;
                            for (int i = 0; i < NUM_NEURONS; i++)
                                cnt[i] <= '0;
                        end
                    end
                    SAMPLE: begin
                        for (int i = 0; i < NUM_NEURONS; i++)
                            if (spike_vec[i] && cnt[i] != CNT_MAX)
                                cnt[i] <= cnt[i] + 1'b1;
                        inhib_out <= (|spike_vec) ? INHIB_WEIGHT : '0;
                        if (step != LAST_STEP) step <= step + 1'b1;
                        scan     <= '0;
                        best_idx <= '0;
                        best_cnt <= '0;
                    end
                    ARGMAX: begin
                        best_idx <= fin_idx;
                        best_cnt <= fin_cnt;
                        scan     <= scan + 1'b1;
                        // Publish with the final compare so the result
                        // is valid while done is high.
                        if (scan == LAST_IDX) begin
                            winner_idx   <= fin_idx;
                            winner_count <= fin_cnt;
                            winner_valid <= |fin_cnt;
                            inhib_out    <= '0;
                        end
                    end
                    DONE:    inhib_out <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snn_timestep_sequencer.sv
// tb_snn_timestep_sequencer: randomized self-checking bench for
// snn_timestep_sequencer against a spike-count/argmax reference model.

module tb_snn_timestep_sequencer;

    localparam int N    = 4;
    localparam int T    = 6;
    localparam int CW   = 2;
    localparam int PW   = 16;
    localparam int IW   = 2;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic signed [PW-1:0] W = -16'sd300;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 in_valid = 1'b0;
    logic [N-1:0]         spike_vec = '0;
    logic                 in_req;
    logic                 neuron_rst;
    logic                 neuron_en;
    logic signed [PW-1:0] inhib_out;
    logic                 busy;
    logic                 done;
    logic [IW-1:0]        winner_idx;
    logic [CW-1:0]        winner_count;
    logic                 winner_valid;

    always #5 clk = ~clk;

    snn_timestep_sequencer #(
        .NUM_NEURONS (N),
        .TIMESTEPS   (T),
        .CNT_WIDTH   (CW),
        .POTENT_WIDTH(PW),
        .INHIB_WEIGHT(W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .in_req      (in_req),
        .in_valid    (in_valid),
        .neuron_rst  (neuron_rst),
        .neuron_en   (neuron_en),
        .spike_vec   (spike_vec),
        .inhib_out   (inhib_out),
        .busy        (busy),
        .done        (done),
        .winner_idx  (winner_idx),
        .winner_count(winner_count),
        .winner_valid(winner_valid)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0] pat [T];
    int           dly [T];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"},
              {in_req, neuron_en, neuron_rst, busy, done, winner_valid},
              64'd0);
        check({tag, "_win"}, {winner_idx, winner_count}, 64'd0);
        check({tag, "_inhib"}, inhib_out, 64'd0);
    endtask

    task automatic clear_stim();
        for (int s = 0; s < T; s++) begin
            pat[s] = '0;
            dly[s] = 0;
        end
    endtask

    // One sample run; abort_at >= 0 aborts in SAMPLE of that step.
    task automatic run_sample(input int abort_at, input bit noise);
        int tot, best, bi, lat, req_exp, limit;
        int exp_cnt [N];
        int s, wc, hold, en_c, req_c, done_c, done_k, busy_c;
        int rst_c, rst_k, ovl, abort_k;
        logic signed [PW-1:0] ih;

        // Reference: saturated spike sums, lowest-index argmax.
        best = 0;
        bi   = 0;
        for (int i = 0; i < N; i++) begin
            tot = 0;
            for (int t = 0; t < T; t++) tot += int'(pat[t][i]);
            exp_cnt[i] = (tot > CMAX) ? CMAX : tot;
            if (exp_cnt[i] > best) begin
                best = exp_cnt[i];
                bi   = i;
            end
        end
        lat     = 3 * T + N + 2;
        req_exp = 0;
        for (int t = 0; t < T; t++) begin
            lat     += dly[t];
            req_exp += dly[t] + 1;
        end

        s = 0; wc = 0; hold = 0; en_c = 0; req_c = 0; done_c = 0;
        done_k = -1; busy_c = 0; rst_c = 0; rst_k = -1; ovl = 0;
        abort_k = -1;
        limit = lat + 40;

        @(negedge clk);
        start = 1'b1;
        abort = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            start = (noise && done_k < 0 && abort_k < 0) ?
                    1'($urandom_range(0, 1)) : 1'b0;
            abort = 1'b0;
            if (abort_k >= 0 && k == abort_k + 1) begin
                check("abort_busy", busy, 64'd0);
                check("abort_inhib", inhib_out, 64'd0);
                check("abort_win",
                      {winner_valid, winner_idx, winner_count}, 64'd0);
            end
            if (abort_k >= 0 && k == abort_k + 4) break;
            if (neuron_rst) begin
                rst_c++;
                rst_k = k;
            end
            if (busy) busy_c++;
            if (in_req) req_c++;
            if (done) begin
                done_c++;
                if (done_k < 0) begin
                    done_k = k;
                    check("win_idx", winner_idx, 64'(bi));
                    check("win_count", winner_count, 64'(best));
                    check("win_valid", winner_valid, 64'(best > 0));
                    check("done_inhib", inhib_out, 64'd0);
                end
            end
            if (done_k >= 0 && k == done_k + 1) begin
                check("idle_busy", busy, 64'd0);
                check("hold_idx", winner_idx, 64'(bi));
                break;
            end
            if (neuron_en) begin
                en_c++;
                if (in_req) ovl++;
                ih = (s > 0 && pat[s-1] != '0) ? W : '0;
                check("step_inhib", inhib_out, ih);
                spike_vec = pat[s];
                hold = 1;
                wc = 0;
                s++;
            end else if (hold != 0) begin
                hold = 0;
                if (s - 1 == abort_at && abort_k < 0) begin
                    abort   = 1'b1;
                    abort_k = k;
                end
            end else begin
                spike_vec = N'($urandom);
            end
            if (in_req && s < T) begin
                in_valid = (wc >= dly[s]);
                wc++;
            end else begin
                in_valid = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        abort = 1'b0;

        if (abort_at < 0) begin
            check("done_once", done_c, 64'd1);
            // done is taken by the consumer on the edge ending DONE.
            check("latency", done_k + 1, 64'(lat));
            check("busy_cycles", busy_c, 64'(lat));
            check("en_pulses", en_c, 64'(T));
            check("req_cycles", req_c, 64'(req_exp));
            check("en_in_req", ovl, 64'd0);
            check("nrst_once", {rst_c, rst_k}, {32'd1, 32'd0});
        end else begin
            check("abort_seen", abort_k >= 0, 64'd1);
            check("abort_no_done", done_c, 64'd0);
            check("abort_en", en_c, 64'(abort_at + 1));
        end
    endtask

    task automatic reset_mid_step();
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b1;
            if (neuron_en) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_step_seen", seen, 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("post_rst");
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        clear_stim();
        run_sample(-1, 1'b0);

        clear_stim();
        pat[0] = 4'b0100;
        pat[2] = 4'b0100;
        run_sample(-1, 1'b0);

        clear_stim();
        pat[1] = 4'b0010;
        pat[4] = 4'b1000;
        run_sample(-1, 1'b0);

        clear_stim();
        dly[1] = 5;
        for (int t = 0; t < 5; t++) pat[t] = 4'b0001;
        run_sample(-1, 1'b0);

        clear_stim();
        pat[1] = 4'b0110;
        pat[2] = 4'b1001;
        run_sample(2, 1'b0);
        run_sample(-1, 1'b0);

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_prio", {busy, neuron_rst}, 64'd0);

        reset_mid_step();
        run_sample(-1, 1'b0);

        for (int r = 0; r < 25; r++) begin
            for (int t = 0; t < T; t++) begin
                pat[t] = N'($urandom) & N'($urandom);
                dly[t] = ($urandom_range(0, 2) == 0) ?
                         int'($urandom_range(1, 3)) : 0;
            end
            run_sample((r % 6 == 5) ? int'($urandom_range(0, T - 1)) : -1,
                       1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
